// File: rtl/lfm_dds_pkg.sv
// Shared types and constants for the chirp DDS: state encoding, widths and
// the elaboration-time sine table builder.
package lfm_dds_pkg;

    localparam int unsigned N_PHASE   = 32;
    localparam int unsigned LUT_BITS  = 10;
    localparam int unsigned LUT_SIZE  = 1 << LUT_BITS;
    localparam int unsigned OUT_WIDTH = 16;
    localparam int unsigned LUT_WIDTH = 10;
    localparam int unsigned FRAC_W    = 32;
    localparam int unsigned FREQ_W    = N_PHASE + FRAC_W;
    localparam int unsigned DIV_W     = N_PHASE + 64;
    localparam int unsigned HZ_W      = 32;
    localparam int unsigned LEN_W     = 64;
    localparam int unsigned ROM_W     = LUT_SIZE * LUT_WIDTH;
    localparam int unsigned ROM_AW    = $clog2(ROM_W);
    localparam int unsigned AMP       = (1 << (LUT_WIDTH - 1)) - 1;
    localparam real         PI        = 3.14159265358979323846;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC0 = 3'd1,
        CALC1 = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [HZ_W-1:0]  f_start;
        logic [HZ_W-1:0]  f_stop;
        logic [LEN_W-1:0] chirp_len;
        logic [HZ_W-1:0]  f_clk;
    } chirp_cfg_t;

    // Full-wave rounded sine, packed LUT_WIDTH bits per entry; nested loops keep each loop short
    function automatic logic [ROM_W-1:0] build_sine_rom();
        logic [ROM_W-1:0] rom;
        real v;
        int  r;
        int  idx;
        rom = '0;
        for (int hi = 0; hi < int'(LUT_SIZE / 32); hi++) begin
            for (int lo = 0; lo < 32; lo++) begin
                idx = hi * 32 + lo;
                v   = real'(AMP) * $sin(2.0 * PI * real'(idx) / real'(LUT_SIZE));
                r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
                rom = rom | (ROM_W'(LUT_WIDTH'(unsigned'(r))) << (idx * LUT_WIDTH));
            end
        end
        return rom;
    endfunction

endpackage

// File: rtl/lfm_dds_if.sv
// Chirp configuration, launch strobe and generated-sample bus of lfm_dds.
interface lfm_dds_if;
    import lfm_dds_pkg::*;

    logic [HZ_W-1:0]             f_start;
    logic [HZ_W-1:0]             f_stop;
    logic [LEN_W-1:0]            chirp_len;
    logic [HZ_W-1:0]             f_clk;
    logic                        start;
    logic                        done;
    logic [FREQ_W-1:0]           current_freq;
    logic signed [OUT_WIDTH-1:0] dout;

    modport master (output f_start, f_stop, chirp_len, f_clk, start,
                    input  done, current_freq, dout);
    modport slave  (input  f_start, f_stop, chirp_len, f_clk, start,
                    output done, current_freq, dout);
endinterface

// File: rtl/lfm_divider.sv
// Unsigned restoring divider, one quotient bit per clock, WIDTH clocks per
// division; the first bit is resolved on the start edge itself.
module lfm_divider #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned QW    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_in_c, quo_in_c, dvs_c, rem_nx_c, quo_nx_c;
    logic [WIDTH:0]   trial_c;
    logic             qbit_c;

    // One restoring step; a zero divisor always subtracts, giving an all-ones quotient
    always_comb begin
        rem_in_c = start ? '0 : rem_q;
        quo_in_c = start ? dividend : quo_q;
        dvs_c    = start ? divisor : dvs_q;
        trial_c  = {rem_in_c, quo_in_c[WIDTH-1]};
        qbit_c   = 1'b0;
        rem_nx_c = trial_c[WIDTH-1:0];
        if (trial_c >= {1'b0, dvs_c}) begin
            qbit_c   = 1'b1;
            rem_nx_c = WIDTH'(trial_c - {1'b0, dvs_c});
        end
        quo_nx_c = {quo_in_c[WIDTH-2:0], qbit_c};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= rem_nx_c;
                quo_q <= quo_nx_c;
                dvs_q <= divisor;
                cnt_q <= CW'(WIDTH - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= rem_nx_c;
                quo_q <= quo_nx_c;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q[QW-1:0];
endmodule

// File: rtl/lfm_dds.sv
// Linear-FM chirp DDS: computes start/step tuning words with a shared divider,
// then sweeps a phase accumulator through a registered sine ROM.
module lfm_dds
    import lfm_dds_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    lfm_dds_if.slave   bus
);
    localparam int unsigned SHIFT = OUT_WIDTH - LUT_WIDTH;
    localparam logic [ROM_W-1:0] SINE_ROM = build_sine_rom();

    state_t                      state_q;
    chirp_cfg_t                  cfg_q;
    logic                        dir_q;
    logic [FREQ_W-1:0]           cur_freq_q, step_q;
    logic [N_PHASE-1:0]          phase_q;
    logic [LEN_W-1:0]            count_q;
    logic                        done_q;
    logic signed [OUT_WIDTH-1:0] dout_q;

    logic                        launch_c, div_start_c, div_ready_c, last_c, dir_c;
    logic [HZ_W-1:0]             span_c;
    logic [DIV_W-1:0]            div_dividend_c, div_divisor_c;
    logic [FREQ_W-1:0]           div_quo;
    logic                        div_busy, div_done;
    logic [LUT_BITS-1:0]         lut_addr_c;
    logic [ROM_AW-1:0]           lut_base_c;
    logic signed [LUT_WIDTH-1:0] lut_raw_c;
    logic signed [OUT_WIDTH-1:0] lut_ext_c;

    assign launch_c    = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign div_ready_c = div_done && !div_busy;
    assign dir_c       = cfg_q.f_stop < cfg_q.f_start;
    assign span_c      = dir_c ? (cfg_q.f_start - cfg_q.f_stop) : (cfg_q.f_stop - cfg_q.f_start);
    assign last_c      = (count_q == (cfg_q.chirp_len - LEN_W'(1)));

    // First division launches straight from the ports on the accepting edge
    always_comb begin
        div_start_c    = launch_c;
        div_dividend_c = {bus.f_start, {FREQ_W{1'b0}}};
        div_divisor_c  = DIV_W'(bus.f_clk);
        if (state_q == CALC0) begin
            div_start_c    = div_ready_c;
            div_dividend_c = {span_c, {FREQ_W{1'b0}}};
            div_divisor_c  = DIV_W'(cfg_q.f_clk) * DIV_W'(cfg_q.chirp_len);
        end
    end

    lfm_divider #(.WIDTH(DIV_W), .QW(FREQ_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (div_divisor_c),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign lut_addr_c = phase_q[N_PHASE-1 -: LUT_BITS];
    assign lut_base_c = ROM_AW'(lut_addr_c) * ROM_AW'(LUT_WIDTH);
    assign lut_raw_c  = SINE_ROM[lut_base_c +: LUT_WIDTH];
    assign lut_ext_c  = OUT_WIDTH'(lut_raw_c);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            dir_q      <= 1'b0;
            cur_freq_q <= '0;
            step_q     <= '0;
            phase_q    <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            dout_q     <= '0;
        end else begin
            dout_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        cfg_q.f_start   <= bus.f_start;
                        cfg_q.f_stop    <= bus.f_stop;
                        cfg_q.chirp_len <= bus.chirp_len;
                        cfg_q.f_clk     <= bus.f_clk;
                        phase_q         <= '0;
                        count_q         <= '0;
                        done_q          <= 1'b0;
                        state_q         <= CALC0;
                    end
                end
                CALC0: begin
                    if (div_ready_c) begin
                        cur_freq_q <= div_quo;
                        dir_q      <= dir_c;
                        state_q    <= CALC1;
                    end
                end
                CALC1: begin
                    if (div_ready_c) begin
                        step_q <= div_quo;
                        if (cfg_q.chirp_len == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    phase_q    <= phase_q + cur_freq_q[FREQ_W-1 -: N_PHASE];
                    cur_freq_q <= dir_q ? (cur_freq_q - step_q) : (cur_freq_q + step_q);
                    count_q    <= count_q + LEN_W'(1);
                    // The edge leaving RUN shows zero output, matching DONE
                    if (last_c) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        dout_q <= lut_ext_c <<< SHIFT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done         = done_q;
    assign bus.current_freq = cur_freq_q;
    assign bus.dout         = dout_q;
endmodule

// File: tb/tb_lfm_dds.sv
// Scoreboard bench for lfm_dds: per-cycle expected tuning word, sample and done
// are queued from a reference model at launch and popped as the DUT runs.
module tb_lfm_dds;
    import lfm_dds_pkg::*;

    typedef struct {
        logic [63:0] cf;
        logic [15:0] dout;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    lfm_dds_if bus ();

    lfm_dds dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dout_model(input logic [31:0] ph);
        int  idx;
        real v;
        int  r;
        idx = int'(ph[31:22]);
        v   = 511.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0);
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return 16'(r * 64);
    endfunction

    // Launch a chirp, queue the model's view of n_chk cycles from RUN entry, then compare
    task automatic sweep(input logic [31:0] fs, input logic [31:0] fp, input logic [63:0] len,
                         input logic [31:0] fc, input int n_chk, input int pulse_at);
        logic [127:0] num, den;
        logic [63:0]  f0, d, cf;
        logic [31:0]  ph;
        logic         dir;
        exp_t         e;
        dir = fp < fs;
        num = 128'(fs) << 64;
        f0  = 64'(num / 128'(fc));
        num = 128'(dir ? (fs - fp) : (fp - fs)) << 64;
        den = 128'(fc) * 128'(len);
        d   = (den == '0) ? '1 : 64'(num / den);
        cf  = f0;
        ph  = '0;
        e.cf = f0; e.dout = '0; e.done = (len == '0);
        sb_q.push_back(e);
        for (int k = 1; k < n_chk; k++) begin
            e.dout = '0;
            if (64'(k) <= len) begin
                if (64'(k) < len) e.dout = dout_model(ph);
                ph = ph + cf[63:32];
                cf = dir ? (cf - d) : (cf + d);
            end
            e.cf   = cf;
            e.done = (64'(k) >= len);
            sb_q.push_back(e);
        end

        @(negedge clk);
        bus.f_start = fs; bus.f_stop = fp; bus.chirp_len = len; bus.f_clk = fc;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("done_drop_on_start", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        repeat (191) @(posedge clk);
        #1;
        check("done_before_run", 64'(bus.done), 64'd0);
        check("f0_loaded", bus.current_freq, f0);
        check("dout_before_run", {48'd0, bus.dout}, 64'd0);
        for (int k = 0; k < n_chk; k++) begin
            if (k == pulse_at) begin
                bus.start = 1'b1; bus.f_start = fs + 32'd7;
            end else if (k == pulse_at + 1) begin
                bus.start = 1'b0; bus.f_start = fs;
            end
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("cf[%0d]", k), bus.current_freq, e.cf);
                check($sformatf("dout[%0d]", k), {48'd0, bus.dout}, {48'd0, e.dout});
                check($sformatf("done[%0d]", k), 64'(bus.done), 64'(e.done));
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        bus.f_start = '0; bus.f_stop = '0; bus.chirp_len = '0; bus.f_clk = '0; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_cf", bus.current_freq, 64'd0);
        check("reset_dout", {48'd0, bus.dout}, 64'd0);
        @(negedge clk) rst_n = 1'b0;

        // Bench chirp, interrupted by reset a few cycles into RUN
        sweep(32'd10, 32'd1000, 64'd1_000_000, 32'd100_000_000, 6, -1);
        check("bench_f0_plus_5d", bus.current_freq - 64'd1844674407370, 64'd913113830);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("midrun_reset_cf", bus.current_freq, 64'd0);
        check("midrun_reset_dout", {48'd0, bus.dout}, 64'd0);
        check("midrun_reset_done", 64'(bus.done), 64'd0);
        @(negedge clk) rst_n = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("idle_after_reset_cf", bus.current_freq, 64'd0);
        check("idle_after_reset_done", 64'(bus.done), 64'd0);
        check("idle_after_reset_dout", {48'd0, bus.dout}, 64'd0);

        // Fixed quarter-rate tone
        sweep(32'd25_000_000, 32'd25_000_000, 64'd8, 32'd100_000_000, 12, -1);
        check("tone_ftw", {32'd0, bus.current_freq[63:32]}, 64'h4000_0000);

        // Down-chirp relaunched from DONE, with a start pulse mid-RUN
        sweep(32'd1000, 32'd10, 64'd40, 32'd100_000_000, 44, 5);

        // Zero-length chirp goes straight to DONE
        sweep(32'd100, 32'd200, 64'd0, 32'd100_000_000, 4, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
